rvbridge_write_fifo: RTL

Write-side controller of the raw-video bridge. It acts as an Avalon-ST Video sink: it accepts a video stream, strips packet headers, discards control packets, and pushes active-video pixels into the bridge's dual-clock FIFO. It is the producer counterpart to the bridge's FIFO read controller. It also throttles the upstream source from the FIFO fill level and flags length and overflow errors per frame.

---
 rtl/rvbridge_pkg.sv | 24 ++
 rtl/rvbridge_pkt_parser.sv | 43 ++++
 rtl/rvbridge_write_fifo.sv | 91 +++++++++
 3 files changed

// File: rtl/rvbridge_pkg.sv
// Shared definitions for the raw-video bridge: parser states, packet type
// constants and the parser-to-datapath event bundle.
package rvbridge_pkg;

  localparam int unsigned PKT_TYPE_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_VIDEO   = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  localparam logic [PKT_TYPE_WIDTH-1:0] PKT_TYPE_VIDEO = 4'h0;

  // Per-beat events decoded by the packet parser
  typedef struct packed {
    logic hdr;      // accepted header beat (sop)
    logic pix;      // accepted active-video pixel
    logic pix_eop;  // that pixel also closes the packet
    logic trunc;    // header arrived while a video packet was open
    logic clr_cnt;  // video header: restart the pixel count
  } pkt_evt_t;

endpackage

// File: rtl/rvbridge_pkt_parser.sv
// Avalon-ST Video packet parser: tracks packet context and decodes each
// accepted beat into header / pixel events.
module rvbridge_pkt_parser
  import rvbridge_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      acc_i,
  input  logic                      sop_i,
  input  logic                      eop_i,
  input  logic [PKT_TYPE_WIDTH-1:0] type_i,
  output pkt_evt_t                  evt_c_o
);

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // A header is honoured in every state; an eop only closes a packet body
  always_comb begin
    state_d = state_q;
    if (acc_i && sop_i) begin
      if (eop_i)                         state_d = ST_IDLE;
      else if (type_i == PKT_TYPE_VIDEO) state_d = ST_VIDEO;
      else                               state_d = ST_DISCARD;
    end else if (acc_i && eop_i) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    evt_c_o         = '0;
    evt_c_o.hdr     = acc_i & sop_i;
    evt_c_o.pix     = acc_i & ~sop_i & (state_q == ST_VIDEO);
    evt_c_o.pix_eop = evt_c_o.pix & eop_i;
    evt_c_o.trunc   = evt_c_o.hdr & (state_q == ST_VIDEO);
    evt_c_o.clr_cnt = evt_c_o.hdr & (type_i == PKT_TYPE_VIDEO);
  end

endmodule

// File: rtl/rvbridge_write_fifo.sv
// Write-side controller of the raw-video bridge: sinks an Avalon-ST Video
// stream, pushes active pixels into the DC FIFO and reports frame errors.
module rvbridge_write_fifo
  import rvbridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 24,
  parameter int unsigned FIFO_USED_WIDTH = 10,
  parameter int unsigned FIFO_HIGH_MARK  = 1000,
  parameter int unsigned FRAME_PIXELS    = 2073600,
  parameter int unsigned PIX_CNT_WIDTH   = 22
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH-1:0]      vst_data,
  input  logic                       vst_valid,
  input  logic                       vst_sop,
  input  logic                       vst_eop,
  output logic                       vst_ready,
  output logic                       fifo_aclr,
  output logic                       fifo_wrreq,
  output logic [DATA_WIDTH-1:0]      fifo_data,
  input  logic                       fifo_full,
  input  logic [FIFO_USED_WIDTH-1:0] fifo_usedw,
  output logic                       frame_done,
  output logic                       len_err,
  output logic                       ovf_err
);

  localparam logic [PIX_CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [PIX_CNT_WIDTH-1:0] FRAME_CNT = PIX_CNT_WIDTH'(FRAME_PIXELS);

  logic                     acc_c;
  pkt_evt_t                 evt_c;
  logic [PIX_CNT_WIDTH-1:0] pix_cnt_q, pix_cnt_d, pix_cnt_inc_c;
  logic                     vst_ready_q, vst_ready_d;
  logic                     frame_done_q, frame_done_d;
  logic                     len_err_q, len_err_d;
  logic                     ovf_err_q, ovf_err_d;

  assign acc_c = vst_valid & vst_ready_q;

  rvbridge_pkt_parser u_parser (
    .clk     (clk),
    .rst_n   (rst_n),
    .acc_i   (acc_c),
    .sop_i   (vst_sop),
    .eop_i   (vst_eop),
    .type_i  (vst_data[PKT_TYPE_WIDTH-1:0]),
    .evt_c_o (evt_c)
  );

  // Zero-latency FIFO write path; pixels seen while full are dropped
  assign fifo_wrreq = evt_c.pix & ~fifo_full;
  assign fifo_data  = vst_data;
  assign fifo_aclr  = ~rst_n;

  always_comb begin
    pix_cnt_inc_c = (pix_cnt_q == CNT_MAX) ? CNT_MAX : pix_cnt_q + PIX_CNT_WIDTH'(1);
    pix_cnt_d     = pix_cnt_q;
    if (evt_c.clr_cnt)  pix_cnt_d = '0;
    else if (evt_c.pix) pix_cnt_d = pix_cnt_inc_c;

    frame_done_d = evt_c.pix_eop;
    len_err_d    = evt_c.trunc | (evt_c.pix_eop & (pix_cnt_inc_c != FRAME_CNT));
    ovf_err_d    = evt_c.pix & fifo_full;
    // Headroom above the mark covers the one-cycle ready turnaround
    vst_ready_d  = 32'(fifo_usedw) < 32'(FIFO_HIGH_MARK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_q    <= '0;
      vst_ready_q  <= 1'b0;
      frame_done_q <= 1'b0;
      len_err_q    <= 1'b0;
      ovf_err_q    <= 1'b0;
    end else begin
      pix_cnt_q    <= pix_cnt_d;
      vst_ready_q  <= vst_ready_d;
      frame_done_q <= frame_done_d;
      len_err_q    <= len_err_d;
      ovf_err_q    <= ovf_err_d;
    end
  end

  assign vst_ready  = vst_ready_q;
  assign frame_done = frame_done_q;
  assign len_err    = len_err_q;
  assign ovf_err    = ovf_err_q;

endmodule
